// File: rtl/stream_packet_arbiter.sv
// Round-robin, packet-atomic arbiter merging NUM_PORTS word streams onto one parser ingress.
// Optional per-port completed-packet counters are built when ARB_STATS_EN is defined.
module stream_packet_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32
`ifdef ARB_STATS_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS-1:0]          in_val,
  input  logic [NUM_PORTS-1:0]          in_last,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_val,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [NUM_PORTS-1:0]          grant,
  output logic                          busy
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0]    pkt_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {ARB, XFER} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     gidx, gidx_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W:0]       cand;
  logic                 found;
  logic [NUM_PORTS-1:0] grant_nxt;
  logic [DATA_W-1:0]    port_data [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_split
    assign port_data[p] = in_data[p*DATA_W +: DATA_W];
  end

  // First requesting port at or after rr_ptr, wrapping by explicit compare
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
      if (!found && in_val[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
  end

  // Next-state and pass-through outputs
  always_comb begin
    state_nxt  = state;
    gidx_nxt   = gidx;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant;
    in_ready   = '0;
    out_data   = '0;
    out_val    = 1'b0;
    out_last   = 1'b0;
    case (state)
      ARB: begin
        if (found) begin
          state_nxt = XFER;
          gidx_nxt  = sel;
          grant_nxt = NUM_PORTS'(1) << sel;
        end
      end
      XFER: begin
        out_data       = port_data[gidx];
        out_val        = in_val[gidx];
        out_last       = in_last[gidx];
        in_ready[gidx] = out_ready;
        if (in_val[gidx] && out_ready && in_last[gidx]) begin
          state_nxt  = ARB;
          grant_nxt  = '0;
          rr_ptr_nxt = (gidx == IDX_W'(NUM_PORTS - 1)) ? '0 : gidx + IDX_W'(1);
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB;
      gidx   <= '0;
      rr_ptr <= '0;
      grant  <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      gidx   <= gidx_nxt;
      rr_ptr <= rr_ptr_nxt;
      grant  <= grant_nxt;
      busy   <= (state_nxt == XFER);
    end
  end

`ifdef ARB_STATS_EN
  // Completed-packet counters, wrap naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (state == XFER && in_val[gidx] && out_ready && in_last[gidx]) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (gidx == IDX_W'(p)) pkt_cnt[p*CNT_W +: CNT_W] <= pkt_cnt[p*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Randomized bench for stream_packet_arbiter against a packet-level round-robin reference model.
// Checks pkt_cnt as well when ARB_STATS_EN is defined.
module tb_stream_packet_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_val, in_last, in_ready;
  logic [W-1:0]     out_data;
  logic             out_val, out_last, out_ready;
  logic [N-1:0]     grant;
  logic             busy;
`ifdef ARB_STATS_EN
  logic [N*CW-1:0]  pkt_cnt;
`endif

  always #5 clk = ~clk;

  stream_packet_arbiter #(
    .NUM_PORTS(N),
    .DATA_W(W)
`ifdef ARB_STATS_EN
    ,
    .CNT_W(CW)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_val(in_val),
    .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_val(out_val),
    .out_last(out_last),
    .out_ready(out_ready),
    .grant(grant),
    .busy(busy)
`ifdef ARB_STATS_EN
    ,
    .pkt_cnt(pkt_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: current owner (-1 = arbitrating), round-robin start, per-port sources
  int owner, ptr;
  int beat [N];
  int len [N];
  int pkt_no [N];
  int cnt [N];
  int val_pct, rdy_pct;
  logic [N-1:0] en_mask;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      in_data[p*W +: W] = {8'(p), 8'(pkt_no[p]), 8'(beat[p]), 8'(len[p])};
      in_last[p]        = (beat[p] == len[p] - 1);
      in_val[p]         = en_mask[p] && ($urandom_range(99) < val_pct);
    end
    out_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic cycle();
    logic [N-1:0] eg, er;
    logic [W-1:0] ed;
    logic         ev, el, rst;
    int           acc, nowner, nptr, q;
    bit           hit;
    @(negedge clk);
    eg = '0; er = '0; ed = '0; ev = 1'b0; el = 1'b0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      er[owner] = out_ready;
      ed = in_data[owner*W +: W];
      ev = in_val[owner];
      el = in_last[owner];
    end
    check_eq("grant", 64'(grant), 64'(eg));
    check_eq("busy", 64'(busy), 64'(owner >= 0));
    check_eq("in_ready", 64'(in_ready), 64'(er));
    check_eq("out_val", 64'(out_val), 64'(ev));
    check_eq("out_data", 64'(out_data), 64'(ed));
    check_eq("out_last", 64'(out_last), 64'(el));
`ifdef ARB_STATS_EN
    for (int p = 0; p < N; p++) check_eq("pkt_cnt", 64'(pkt_cnt[p*CW +: CW]), 64'(CW'(cnt[p])));
`endif
    acc = -1;
    nowner = owner;
    nptr = ptr;
    if (owner >= 0) begin
      if (in_val[owner] && out_ready) acc = owner;
      if (acc >= 0 && in_last[acc]) begin
        nowner = -1;
        nptr = (acc + 1) % N;
      end
    end else begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        q = (ptr + k) % N;
        if (!hit && in_val[q]) begin
          hit = 1;
          nowner = q;
        end
      end
    end
    rst = reset;
    @(posedge clk);
    #1;
    if (rst) begin
      owner = -1;
      ptr = 0;
      for (int p = 0; p < N; p++) begin
        cnt[p] = 0;
        beat[p] = 0;
      end
    end else begin
      owner = nowner;
      ptr = nptr;
      if (acc >= 0) begin
        if (beat[acc] == len[acc] - 1) begin
          beat[acc] = 0;
          pkt_no[acc]++;
          len[acc] = $urandom_range(4, 1);
          cnt[acc]++;
        end else begin
          beat[acc]++;
        end
      end
    end
    drive();
  endtask

  task automatic run(input int cycles, input int vp, input int rp, input logic [N-1:0] mask);
    val_pct = vp;
    rdy_pct = rp;
    en_mask = mask;
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  initial begin
    bit reached;
    reset = 1'b1;
    in_data = '0;
    in_val = '0;
    in_last = '0;
    out_ready = 1'b0;
    owner = -1;
    ptr = 0;
    for (int p = 0; p < N; p++) begin
      beat[p] = 0;
      pkt_no[p] = 0;
      cnt[p] = 0;
      len[p] = $urandom_range(4, 1);
    end
    len[2] = 3;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    val_pct = 100;
    rdy_pct = 100;
    en_mask = 4'b0100;
    drive();

    // Lone 3-beat packet on port 2, then full-load fairness with 2-beat packets
    run(8, 100, 100, 4'b0100);
    for (int p = 0; p < N; p++) len[p] = 2;
    run(40, 100, 100, 4'b1111);
    // Random valid gaps and output backpressure
    run(500, 70, 50, 4'b1111);
    run(300, 60, 20, 4'b1111);
    run(200, 40, 90, 4'b1010);

    // Reset in the middle of a multi-beat packet
    reached = 0;
    val_pct = 100;
    rdy_pct = 100;
    en_mask = 4'b1111;
    for (int i = 0; i < 200 && !reached; i++) begin
      cycle();
      if (owner >= 0 && beat[owner] >= 1) reached = 1;
    end
    check_eq("reset_mid_reached", 64'(reached), 64'(1));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(10, 100, 100, 4'b1111);

    run(400, 90, 80, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
